// File: rtl/sc_game_flow_sequencer.sv
// sc_game_flow_sequencer: Frogger game-flow controller. Sequences start, play,
// hit, goal, game-over and win phases, owns lives/level, pulses the datapath
// clear and generates the level-dependent lane-advance tick.
// Optional feature macro: SC_GAMEFLOW_PAUSE_EN adds pauseButton_InLow and a
// PAUSED state; state_Out widens to 4 bits.
module sc_game_flow_sequencer #(
    parameter int LIVES_INIT  = 3,
    parameter int LEVEL_MAX   = 4,
    parameter int TICK_BASE   = 2_500_000,
    parameter int TICK_STEP   = 500_000,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic       SC_STATEMACHINEGENERAL_CLOCK_50,
    input  logic       SC_STATEMACHINEGENERAL_RESET_InHigh,
    input  logic       startButton_InLow,
`ifdef SC_GAMEFLOW_PAUSE_EN
    input  logic       pauseButton_InLow,
`endif
    input  logic       frogCollision_InHigh,
    input  logic       frogGoal_InHigh,
    output logic       clear_OutLow,
    output logic       laneTick_Out,
    output logic [2:0] level_Out,
    output logic [2:0] lives_Out,
    output logic       gameOver_Out,
    output logic       win_Out,
`ifdef SC_GAMEFLOW_PAUSE_EN
    output logic [3:0] state_Out
`else
    output logic [2:0] state_Out
`endif
);

`ifdef SC_GAMEFLOW_PAUSE_EN
    localparam int SW = 4;
`else
    localparam int SW = 3;
`endif

    // Every level must still leave a positive tick period.
    if (TICK_BASE <= LEVEL_MAX * TICK_STEP) begin : g_bad_tick_params
        $error("TICK_BASE must exceed LEVEL_MAX*TICK_STEP");
    end

    typedef enum logic [SW-1:0] {
        S_RESET_0   = SW'(0),
        S_IDLE      = SW'(1),
        S_CLEAR     = SW'(2),
        S_PLAY      = SW'(3),
        S_HIT       = SW'(4),
        S_GOAL      = SW'(5),
        S_GAME_OVER = SW'(6),
        S_WIN       = SW'(7)
`ifdef SC_GAMEFLOW_PAUSE_EN
        // WIN already owns 7, so PAUSED takes the first code of the wider field.
        , S_PAUSED  = SW'(8)
`endif
    } state_t;

    localparam logic [25:0] TICK_BASE26 = 26'(TICK_BASE);
    localparam logic [25:0] TICK_STEP26 = 26'(TICK_STEP);
    localparam logic [25:0] HOLD_LAST   = 26'(HOLD_CYCLES - 1);
    localparam logic [2:0]  LIVES0      = 3'(LIVES_INIT);
    localparam logic [2:0]  LEVEL_TOP   = 3'(LEVEL_MAX);

    logic        clk, rst;
    assign clk = SC_STATEMACHINEGENERAL_CLOCK_50;
    assign rst = SC_STATEMACHINEGENERAL_RESET_InHigh;

    state_t      state_q, state_d;
    logic [2:0]  lives_q, lives_d, level_q, level_d;
    logic [25:0] tick_cnt_q, tick_cnt_d, hold_cnt_q, hold_cnt_d;
    logic        clear_n_q, clear_n_d, tick_q, tick_d, gover_q, gover_d, win_q, win_d;
    logic        st_s1_q, st_s1_d, st_s2_q, st_s2_d, st_prev_q, st_prev_d, st_pulse_q, st_pulse_d;
    logic [25:0] period;

`ifdef SC_GAMEFLOW_PAUSE_EN
    logic        pa_s1_q, pa_s1_d, pa_s2_q, pa_s2_d, pa_prev_q, pa_prev_d, pa_pulse_q, pa_pulse_d;

    // Pause key: 2-FF synchronizer, falling-edge detect, registered pulse.
    always_comb begin
        pa_s1_d    = pauseButton_InLow;
        pa_s2_d    = pa_s1_q;
        pa_prev_d  = pa_s2_q;
        pa_pulse_d = pa_prev_q & ~pa_s2_q;
    end

    // Pause synchronizer registers idle high (key released).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pa_s1_q <= 1'b1; pa_s2_q <= 1'b1; pa_prev_q <= 1'b1; pa_pulse_q <= 1'b0;
        end else begin
            pa_s1_q <= pa_s1_d; pa_s2_q <= pa_s2_d; pa_prev_q <= pa_prev_d; pa_pulse_q <= pa_pulse_d;
        end
    end
`endif

    // Start key: 2-FF synchronizer, falling-edge detect, registered pulse
    // (pulse lands 3 cycles after the press; a held key yields one pulse).
    always_comb begin
        st_s1_d    = startButton_InLow;
        st_s2_d    = st_s1_q;
        st_prev_d  = st_s2_q;
        st_pulse_d = st_prev_q & ~st_s2_q;
    end

    // Start synchronizer registers idle high (key released).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_s1_q <= 1'b1; st_s2_q <= 1'b1; st_prev_q <= 1'b1; st_pulse_q <= 1'b0;
        end else begin
            st_s1_q <= st_s1_d; st_s2_q <= st_s2_d; st_prev_q <= st_prev_d; st_pulse_q <= st_pulse_d;
        end
    end

    assign period = TICK_BASE26 - 26'(level_q) * TICK_STEP26;

    // Next-state, counters and registered-output values; outputs follow state_d
    // so they change on the same edge as the state register.
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        tick_cnt_d = '0;
        hold_cnt_d = '0;
        tick_d     = 1'b0;
        case (state_q)
            S_RESET_0: state_d = S_IDLE;
            S_IDLE, S_GAME_OVER, S_WIN: begin
                if (st_pulse_q) begin
                    state_d = S_CLEAR;
                    level_d = '0;
                    lives_d = LIVES0;
                end
            end
            S_CLEAR: state_d = S_PLAY;
            S_PLAY: begin
                if (frogCollision_InHigh) begin
                    state_d = S_HIT;
                    lives_d = (lives_q != '0) ? lives_q - 3'd1 : '0;
                end else if (frogGoal_InHigh) begin
                    state_d = S_GOAL;
`ifdef SC_GAMEFLOW_PAUSE_EN
                end else if (pa_pulse_q) begin
                    state_d    = S_PAUSED;
                    tick_cnt_d = tick_cnt_q;
`endif
                end else if (tick_cnt_q == period - 26'd1) begin
                    tick_d = 1'b1;
                end else begin
                    tick_cnt_d = tick_cnt_q + 26'd1;
                end
            end
`ifdef SC_GAMEFLOW_PAUSE_EN
            S_PAUSED: begin
                tick_cnt_d = tick_cnt_q;
                if (pa_pulse_q) state_d = S_PLAY;
            end
`endif
            S_HIT: begin
                if (hold_cnt_q == HOLD_LAST) state_d = (lives_q == '0) ? S_GAME_OVER : S_CLEAR;
                else                         hold_cnt_d = hold_cnt_q + 26'd1;
            end
            S_GOAL: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    if (level_q >= LEVEL_TOP) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_CLEAR;
                        level_d = level_q + 3'd1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 26'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        clear_n_d = (state_d != S_RESET_0) && (state_d != S_CLEAR);
        gover_d   = (state_d == S_GAME_OVER);
        win_d     = (state_d == S_WIN);
    end

    // State, counters and output registers; async reset to the power-on values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RESET_0;
            lives_q    <= LIVES0;
            level_q    <= '0;
            tick_cnt_q <= '0;
            hold_cnt_q <= '0;
            clear_n_q  <= 1'b0;
            tick_q     <= 1'b0;
            gover_q    <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            tick_cnt_q <= tick_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            clear_n_q  <= clear_n_d;
            tick_q     <= tick_d;
            gover_q    <= gover_d;
            win_q      <= win_d;
        end
    end

    assign clear_OutLow = clear_n_q;
    assign laneTick_Out = tick_q;
    assign level_Out    = level_q;
    assign lives_Out    = lives_q;
    assign gameOver_Out = gover_q;
    assign win_Out      = win_q;
    assign state_Out    = state_q;

endmodule
